fifo_status: RTL and testbench
==============================

Name: fifo_status

Overview:
Parametrised synchronous circular-buffer FIFO; next generation of the team's basic FIFO. Adds:
- an occupancy counter
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- defined simultaneous read/write behaviour at both full and empty

Sits between producer and consumer blocks in one clock domain.

Parameters:
B, 8, data word width in bits
W, 4, address bits; DEPTH = 2**W words
AF_LEVEL, 2**W-2, almost_full asserted when count >= AF_LEVEL (legal range 1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (legal range 0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr  input  1  write request
w_data  input  B  write data
rd  input  1  read request (acknowledge of current r_data)
r_data  output  B  show-ahead data at read pointer; valid only while empty=0
clr_err  input  1  synchronous clear of overflow/underflow
empty  output  1  FIFO holds 0 words
full  output  1  FIFO holds DEPTH words
almost_empty  output  1  count <= AE_LEVEL
almost_full  output  1  count >= AF_LEVEL
count  output  W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (clk edge with reset=1):
  - pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Storage array is not reset.
  - Reset overrides every other input, including mid-transfer.
- All status outputs are registered, or decoded from registered count/pointers only. No combinational path from wr/rd to any status output.
- Pointers are W bits and wrap naturally from DEPTH-1 to 0. Full/empty are derived from count, not from pointer equality.
- Accept rules:
  - do_rd = rd & ~empty
  - do_wr = wr & (~full | rd)
  - A write into a full FIFO is accepted only when a read occurs in the same cycle.
- Write: on do_wr, array[w_ptr] <= w_data and w_ptr increments.
- Read: on do_rd, r_ptr increments. r_data = array[r_ptr] combinationally, so the first word is visible the cycle after its write (first-word latency 1 cycle).
- Count update:
  - +1 on do_wr & ~do_rd
  - -1 on do_rd & ~do_wr
  - unchanged when both or neither occur
- Simultaneous wr & rd:
  - Empty: only the write occurs. Count 0->1, empty falls next cycle, no underflow.
  - Full: both occur. Count stays DEPTH, full stays 1, no overflow.
  - Otherwise: both occur, count unchanged.
- Error flags:
  - overflow <= 1 when wr & full & ~rd.
  - underflow <= 1 when rd & empty & ~wr.
  - rd & wr while empty is not an underflow.
  - Both flags hold until reset or clr_err.
  - If clr_err and a new error event occur in the same cycle, the event wins and the flag stays 1.
- Rejected operations leave pointers, count and array unchanged.
- Threshold flags follow registered count in the same cycle as empty/full.

Decomposition:
- Shared package fifo_pkg:
  - function clog2
  - localparams DEPTH = 2**W and CW = W+1
  - enum for the {wr,rd} operation codes (IDLE, READ, WRITE, BOTH), reused by future FIFO variants
- One sub-module, fifo_regfile: B x DEPTH array, synchronous write port, asynchronous read port.
- fifo_status holds pointers, count, flags and accept logic.

Test Plan (B=8, W=2 so DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
1. Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_empty drops at count=2; almost_full rises at count=3; full=1 after 4th edge; r_data=0x11 throughout.
2. From full, wr=1 with w_data=0x55, rd=0 -> overflow=1, count stays 4. Then read 4 times -> r_data sequence 0x11,0x22,0x33,0x44, empty=1. Then rd=1 alone -> underflow=1.
3. Fill 3 words, then read/write 10 cycles so pointers wrap twice -> data order preserved, count constant 3, no error flags.
4. Empty with wr=1, rd=1, w_data=0xA5 -> count 1, empty 0, underflow 0, r_data=0xA5 next cycle.
5. Full with wr=1, rd=1 -> count stays 4, full stays 1, oldest word consumed, new word at tail, overflow 0.
6. Assert reset with count=2 and overflow=1 -> next cycle count=0, empty=1, overflow=0. Then assert clr_err together with an overflow event -> overflow remains 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: sizing helpers, default geometry
// and the request/operation encoding used by every variant.
package fifo_pkg;

  localparam int FIFO_DEF_W = 4;
  localparam int DEPTH      = 2 ** FIFO_DEF_W;
  localparam int CW         = FIFO_DEF_W + 1;

  // {wr, rd} packed as a two-bit operation code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    BOTH  = 2'b11
  } op_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// B x DEPTH storage for the FIFO: one synchronous write port and one
// asynchronous (show-ahead) read port. Contents are deliberately not reset.
module fifo_regfile #(
  parameter int B     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = fifo_pkg::clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] w_addr,
  input  logic [B-1:0]  w_data,
  input  logic [AW-1:0] r_addr,
  output logic [B-1:0]  r_data
);

  logic [B-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[w_addr] <= w_data;
    end
  end

  assign r_data = mem_q[r_addr];

endmodule

// File: rtl/fifo_status.sv
// Synchronous circular-buffer FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_status #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = 2 ** W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  input  logic         clr_err,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int DEPTH = 2 ** W;
  localparam int CW    = W + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Handshake: wr pushes w_data and is accepted when not full, or when full
  // and a read frees a slot in the same cycle; rd acknowledges the word on
  // r_data and is accepted only when non-empty. Rejected requests change
  // nothing except the sticky error flags.

  logic [W-1:0]  w_ptr_q, w_ptr_d;
  logic [W-1:0]  r_ptr_q, r_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          almost_empty_q, almost_empty_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          do_wr;
  logic          do_rd;
  fifo_pkg::op_e req_op;
  fifo_pkg::op_e acc_op;

  always_comb begin
    do_rd  = rd & ~empty_q;
    do_wr  = wr & (~full_q | rd);
    req_op = fifo_pkg::op_e'({wr, rd});
    acc_op = fifo_pkg::op_e'({do_wr, do_rd});

    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;

    if (do_wr) begin
      w_ptr_d = w_ptr_q + W'(1);
    end
    if (do_rd) begin
      r_ptr_d = r_ptr_q + W'(1);
    end

    case (acc_op)
      fifo_pkg::WRITE: count_d = count_q + CW'(1);
      fifo_pkg::READ:  count_d = count_q - CW'(1);
      default:         count_d = count_q;
    endcase

    // Status flags are registered copies of the next count, so they change
    // in the same cycle as count and never see wr/rd combinationally.
    empty_d        = (count_d == '0);
    full_d         = (count_d == DEPTH_C);
    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);

    // A new error event beats a simultaneous clear.
    overflow_d  = ((req_op == fifo_pkg::WRITE) & full_q)
                | (overflow_q & ~clr_err);
    underflow_d = ((req_op == fifo_pkg::READ) & empty_q)
                | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q        <= '0;
      r_ptr_q        <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      w_ptr_q        <= w_ptr_d;
      r_ptr_q        <= r_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  fifo_regfile #(
    .B     (B),
    .DEPTH (DEPTH),
    .AW    (W)
  ) u_regfile (
    .clk    (clk),
    .we     (do_wr & ~reset),
    .w_addr (w_ptr_q),
    .w_data (w_data),
    .r_addr (r_ptr_q),
    .r_data (r_data)
  );

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_status.sv
// Directed bench for fifo_status (DEPTH=4, AF=3, AE=1): queue-based model
// checked every cycle, plus hand-computed literal expectations.
module tb_fifo_status;

  localparam int B        = 8;
  localparam int W        = 2;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
  localparam int AE_LEVEL = 1;

  logic         clk;
  logic         reset;
  logic         wr;
  logic [B-1:0] w_data;
  logic         rd;
  logic [B-1:0] r_data;
  logic         clr_err;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  fifo_status #(
    .B        (B),
    .W        (W),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .clr_err      (clr_err),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model and scoreboard state
  logic [B-1:0] exp_q[$];
  logic         m_ovf;
  logic         m_udf;
  bit           checking;
  int           n_checks;
  int           n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the request seen at the clock edge.
  task automatic model_step(input logic i_wr, input logic i_rd, input logic [B-1:0] d,
                            input logic i_clr, input logic i_rst);
    int  n;
    bit  take;
    bit  put;
    if (i_rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      n    = exp_q.size();
      take = i_rd && (n > 0);
      put  = i_wr && ((n < DEPTH) || i_rd);
      if (i_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (i_wr && !i_rd && n == DEPTH) m_ovf = 1'b1;
      if (i_rd && !i_wr && n == 0)     m_udf = 1'b1;
      if (take) void'(exp_q.pop_front());
      if (put)  exp_q.push_back(d);
    end
  endtask

  // driver
  task automatic step(input logic i_wr, input logic i_rd, input logic [B-1:0] d,
                      input logic i_clr, input logic i_rst);
    wr      = i_wr;
    rd      = i_rd;
    w_data  = d;
    clr_err = i_clr;
    reset   = i_rst;
    @(posedge clk);
    model_step(i_wr, i_rd, d, i_clr, i_rst);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic push(input logic [B-1:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  // compare process: every cycle once the DUT has been reset
  always @(negedge clk) begin
    if (checking) begin
      int n;
      n = exp_q.size();
      chk("cmp_count", 32'(count), 32'(n));
      chk("cmp_empty", 32'(empty), 32'(n == 0));
      chk("cmp_full", 32'(full), 32'(n == DEPTH));
      chk("cmp_almost_full", 32'(almost_full), 32'(n >= AF_LEVEL));
      chk("cmp_almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
      chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
      chk("cmp_underflow", 32'(underflow), 32'(m_udf));
      if (n > 0) chk("cmp_r_data", 32'(r_data), 32'(exp_q[0]));
    end
  end

  initial begin
    logic [B-1:0] t1 [4];
    logic [B-1:0] exp_head;
    n_checks = 0;
    n_fail   = 0;
    checking = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    w_data   = '0;
    clr_err  = 1'b0;
    reset    = 1'b1;
    t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;

    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checking = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_errs", 32'({overflow, underflow}), 32'd0);

    // 1: fill
    for (int i = 0; i < 4; i++) begin
      push(t1[i]);
      chk("t1_count", 32'(count), 32'(i + 1));
      chk("t1_r_data", 32'(r_data), 32'h11);
      chk("t1_almost_empty", 32'(almost_empty), 32'(i == 0));
      chk("t1_almost_full", 32'(almost_full), 32'(i >= 2));
      chk("t1_full", 32'(full), 32'(i == 3));
    end

    // 2: overflow, drain, underflow
    push(8'h55);
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_r_data", 32'(r_data), 32'(t1[i]));
      pop();
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_underflow_pre", 32'(underflow), 32'd0);
    pop();
    chk("t2_underflow", 32'(underflow), 32'd1);
    chk("t2_overflow_hold", 32'(overflow), 32'd1);

    // 3: pointer wrap under simultaneous read/write
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_clr", 32'({overflow, underflow}), 32'd0);
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i));
    for (int i = 0; i < 10; i++) begin
      exp_head = (i < 3) ? 8'(8'h60 + i) : 8'(8'h70 + i - 3);
      chk("t3_r_data", 32'(r_data), 32'(exp_head));
      step(1'b1, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      chk("t3_count", 32'(count), 32'd3);
    end
    chk("t3_errs", 32'({overflow, underflow}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_tail", 32'(r_data), 32'(8'h77 + i));
      pop();
    end

    // 4: read+write while empty
    step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_empty", 32'(empty), 32'd0);
    chk("t4_underflow", 32'(underflow), 32'd0);
    chk("t4_r_data", 32'(r_data), 32'hA5);

    // 5: read+write while full
    push(8'hB1); push(8'hB2); push(8'hB3);
    chk("t5_full_pre", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'hC4, 1'b0, 1'b0);
    chk("t5_count", 32'(count), 32'd4);
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_head", 32'(r_data), 32'hB1);
    pop(); pop(); pop();
    chk("t5_tail", 32'(r_data), 32'hC4);
    pop();

    // 6: reset mid-state, then clear racing a new overflow
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    push(8'hD4);
    pop(); pop();
    chk("t6_count_pre", 32'(count), 32'd2);
    chk("t6_overflow_pre", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_overflow", 32'(overflow), 32'd0);
    push(8'hE0); push(8'hE1); push(8'hE2); push(8'hE3);
    step(1'b1, 1'b0, 8'hE4, 1'b1, 1'b0);
    chk("t6_clr_vs_event", 32'(overflow), 32'd1);
    chk("t6_count_hold", 32'(count), 32'd4);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_clr", 32'(overflow), 32'd0);
    chk("t6_data_kept", 32'(r_data), 32'hE0);

    @(negedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
